tl_egress: RTL and testbench

Egress transport-layer interface: consumes 32-bit flits ejected from the local router output port, buffers them per virtual channel, reassembles whole packets and drives them out as an AXI stream (24-bit beats, tuser = packet destination tag). Sits directly downstream of the router ejection port, mirroring the ingress transport-layer interface. Upstream flow control is credit-based: one credit is returned per flit popped from a VC buffer.

---
 rtl/tl_egress_if.sv | 28 ++
 rtl/tl_egress.sv | 276 +++++++++++++++++++++++++++
 tb/tb_tl_egress.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_egress_if.sv
// Egress bundle for tl_egress: router flit ejection, credit return and the
// outgoing AXI stream. The master modport is the tl_egress side.
interface tl_egress_if #(
  parameter int D_WIDTH     = 32,
  parameter int AXI_D_WIDTH = 24,
  parameter int VID_BITS    = 6,
  parameter int DEST_BITS   = 4
);
  logic [D_WIDTH-1:0]     flit_in;
  logic                   flit_valid;
  logic                   credit_valid;
  logic [VID_BITS-1:0]    credit_vid;
  logic [AXI_D_WIDTH-1:0] out_tdata;
  logic                   out_tvalid;
  logic                   out_tlast;
  logic [DEST_BITS-1:0]   out_tuser;
  logic                   out_tready;

  modport master (
    input  flit_in, flit_valid, out_tready,
    output credit_valid, credit_vid, out_tdata, out_tvalid, out_tlast, out_tuser
  );

  modport slave (
    output flit_in, flit_valid, out_tready,
    input  credit_valid, credit_vid, out_tdata, out_tvalid, out_tlast, out_tuser
  );
endinterface

// File: rtl/tl_egress.sv
// Egress transport layer: per-VC flit buffers, packet reassembly onto an AXI
// stream, credit return per pop. Optional packet counter: TL_EGRESS_STATS_EN.
module tl_egress #(
  parameter int D_WIDTH     = 32,
  parameter int AXI_D_WIDTH = 24,
  parameter int VID_BITS    = 6,
  parameter int TYPE_BITS   = 2,
  parameter int DEST_BITS   = 4,
  parameter int NUM_VC      = 4,
  parameter int BUF_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  tl_egress_if.master bus,
  output logic        err_overflow,
  output logic        err_proto,
  output logic [15:0] pkt_count
);
  localparam int VC_W  = $clog2(NUM_VC);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // The VID only steers the write, so buffers hold type + payload only
  localparam int FW    = D_WIDTH - VID_BITS;

  localparam logic [TYPE_BITS-1:0] T_CRD  = TYPE_BITS'(0);
  localparam logic [TYPE_BITS-1:0] T_TAIL = TYPE_BITS'(1);
  localparam logic [TYPE_BITS-1:0] T_HDR  = TYPE_BITS'(3);
  localparam logic [VID_BITS:0]    VC_LIM = (VID_BITS+1)'(NUM_VC);
  localparam logic [CNT_W-1:0]     FULL_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [0:0] {ST_IDLE, ST_STREAM} state_t;

  function automatic logic [TYPE_BITS-1:0] word_type(input logic [FW-1:0] w);
    return w[FW-1 -: TYPE_BITS];
  endfunction

  function automatic logic [DEST_BITS-1:0] word_tag(input logic [FW-1:0] w);
    return w[AXI_D_WIDTH-1 -: DEST_BITS];
  endfunction

  logic [FW-1:0]          mem_r [NUM_VC][BUF_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r [NUM_VC];
  logic [PTR_W-1:0]       rd_ptr_r [NUM_VC];
  logic [CNT_W-1:0]       cnt_r [NUM_VC];
  logic [FW-1:0]          head_s [NUM_VC];
  logic [NUM_VC-1:0]      nonempty_s;
  logic [NUM_VC-1:0]      wr_hit_s;
  logic [NUM_VC-1:0]      pop_hit_s;

  logic [VID_BITS-1:0]    wr_vid_s;
  logic [TYPE_BITS-1:0]   wr_type_s;
  logic [VC_W-1:0]        wr_vc_s;
  logic                   wr_en_s;
  logic                   ovf_s;
  logic                   bad_vid_s;

  state_t                 state_r, state_nxt_s;
  logic [VC_W-1:0]        vc_r;
  logic [VC_W-1:0]        rr_ptr_r;
  logic [DEST_BITS-1:0]   tag_r;
  logic [VC_W-1:0]        sel_vc_s;
  logic                   found_s;
  logic [FW-1:0]          strm_head_s;
  logic                   pop_en_s;
  logic [VC_W-1:0]        pop_vc_s;
  logic                   latch_s;
  logic                   proto_s;
  logic                   tail_hs_s;
  logic                   tvalid_s;
  logic                   tlast_s;
  logic [AXI_D_WIDTH-1:0] tdata_s;

  logic                   credit_valid_r;
  logic [VID_BITS-1:0]    credit_vid_r;
  logic                   err_overflow_r;
  logic                   err_proto_r;

  // Write-side decode: legal VID, non-credit type, room by pre-pop occupancy
  always_comb begin
    wr_vid_s  = bus.flit_in[D_WIDTH-1 -: VID_BITS];
    wr_type_s = bus.flit_in[FW-1 -: TYPE_BITS];
    wr_vc_s   = wr_vid_s[VC_W-1:0];
    wr_en_s   = 1'b0;
    ovf_s     = 1'b0;
    bad_vid_s = 1'b0;
    if (bus.flit_valid && (wr_type_s != T_CRD)) begin
      if ({1'b0, wr_vid_s} < VC_LIM) begin
        if (cnt_r[wr_vc_s] == FULL_C) begin
          ovf_s = 1'b1;
        end else begin
          wr_en_s = 1'b1;
        end
      end else begin
        bad_vid_s = 1'b1;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Buffer heads and occupancy flags
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      head_s[v]     = mem_r[v][rd_ptr_r[v]];
      nonempty_s[v] = (cnt_r[v] != CNT_W'(0));
    end
  end

  // Round-robin pick of the first non-empty VC at or after rr_ptr_r
  always_comb begin
    logic [VC_W-1:0] idx_v;
    sel_vc_s = rr_ptr_r;
    found_s  = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx_v = rr_ptr_r + VC_W'(i);
      if (!found_s && nonempty_s[idx_v]) begin
        sel_vc_s = idx_v;
        found_s  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Read FSM next-state, pop control and stream outputs
  always_comb begin
    state_nxt_s = state_r;
    pop_en_s    = 1'b0;
    pop_vc_s    = vc_r;
    latch_s     = 1'b0;
    proto_s     = 1'b0;
    tail_hs_s   = 1'b0;
    tvalid_s    = 1'b0;
    tlast_s     = 1'b0;
    tdata_s     = {AXI_D_WIDTH{1'b0}};
    strm_head_s = head_s[vc_r];
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          pop_en_s = 1'b1;
          pop_vc_s = sel_vc_s;
          if (word_type(head_s[sel_vc_s]) == T_HDR) begin
            latch_s     = 1'b1;
            state_nxt_s = ST_STREAM;
          end else begin
            proto_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (!nonempty_s[vc_r]) begin
          state_nxt_s = ST_STREAM;
        end else if (word_type(strm_head_s) == T_HDR) begin
          // Header in mid-packet: abandon the packet, leave header for IDLE
          proto_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          tvalid_s = 1'b1;
          tdata_s  = strm_head_s[AXI_D_WIDTH-1:0];
          tlast_s  = (word_type(strm_head_s) == T_TAIL);
          if (bus.out_tready) begin
            pop_en_s = 1'b1;
            if (tlast_s) begin
              tail_hs_s   = 1'b1;
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_STREAM;
            end
          end else begin
            state_nxt_s = ST_STREAM;
          end
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-VC write/pop strobes
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      wr_hit_s[v]  = wr_en_s  && (wr_vc_s  == VC_W'(v));
      pop_hit_s[v] = pop_en_s && (pop_vc_s == VC_W'(v));
    end
  end

  // Buffer storage (contents need no reset, pointers gate visibility)
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_vc_s][wr_ptr_r[wr_vc_s]] <= bus.flit_in[FW-1:0];
    end
  end

  // Buffer pointers and occupancy
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (rst) begin
        wr_ptr_r[v] <= PTR_W'(0);
        rd_ptr_r[v] <= PTR_W'(0);
        cnt_r[v]    <= CNT_W'(0);
      end else begin
        if (wr_hit_s[v]) begin
          wr_ptr_r[v] <= wr_ptr_r[v] + PTR_W'(1);
        end
        if (pop_hit_s[v]) begin
          rd_ptr_r[v] <= rd_ptr_r[v] + PTR_W'(1);
        end
        cnt_r[v] <= cnt_r[v] + CNT_W'(wr_hit_s[v]) - CNT_W'(pop_hit_s[v]);
      end
    end
  end

  // FSM state, granted VC, packet tag and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      vc_r     <= VC_W'(0);
      tag_r    <= DEST_BITS'(0);
      rr_ptr_r <= VC_W'(0);
    end else begin
      state_r <= state_nxt_s;
      if (latch_s) begin
        vc_r  <= sel_vc_s;
        tag_r <= word_tag(head_s[sel_vc_s]);
      end
      if (tail_hs_s) begin
        rr_ptr_r <= vc_r + VC_W'(1);
      end
    end
  end

  // Credit return one cycle after each pop; sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_valid_r <= 1'b0;
      credit_vid_r   <= VID_BITS'(0);
      err_overflow_r <= 1'b0;
      err_proto_r    <= 1'b0;
    end else begin
      credit_valid_r <= pop_en_s;
      if (pop_en_s) begin
        credit_vid_r <= {{(VID_BITS-VC_W){1'b0}}, pop_vc_s};
      end
      err_overflow_r <= err_overflow_r | ovf_s;
      err_proto_r    <= err_proto_r | bad_vid_s | proto_s;
    end
  end

  assign bus.out_tvalid   = tvalid_s;
  assign bus.out_tdata    = tdata_s;
  assign bus.out_tlast    = tlast_s;
  assign bus.out_tuser    = tag_r;
  assign bus.credit_valid = credit_valid_r;
  assign bus.credit_vid   = credit_vid_r;
  assign err_overflow     = err_overflow_r;
  assign err_proto        = err_proto_r;

`ifdef TL_EGRESS_STATS_EN
  logic [15:0] pkt_cnt_r;

  // Delivered packets, counted at each tail handshake; wraps at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_r <= 16'd0;
    end else if (tail_hs_s) begin
      pkt_cnt_r <= pkt_cnt_r + 16'd1;
    end
  end

  assign pkt_count = pkt_cnt_r;
`else
  assign pkt_count = 16'd0;
`endif

endmodule

// File: tb/tb_tl_egress.sv
// Directed bench for tl_egress: a per-cycle vector table for the basic and
// interleaved packet flows, plus hand sequences for stall/overflow/error cases.
module tb_tl_egress;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_overflow;
  logic        err_proto;
  logic [15:0] pkt_count;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        rst_b;
    logic        fv;
    logic [31:0] flit;
    logic        rdy;
    logic        tv;
    logic [23:0] td;
    logic        tl;
    logic [3:0]  tu;
    logic        cv;
    logic [5:0]  cvid;
  } vec_t;

  vec_t vecs[17];

  always #5 clk = ~clk;

  tl_egress_if bus ();

  tl_egress dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_overflow(err_overflow),
    .err_proto   (err_proto),
    .pkt_count   (pkt_count)
  );

  function automatic logic [31:0] hdr(input logic [5:0] v, input logic [3:0] t);
    return {v, 2'b11, t, 20'h00000};
  endfunction

  function automatic logic [31:0] body(input logic [5:0] v, input logic [23:0] d);
    return {v, 2'b10, d};
  endfunction

  function automatic logic [31:0] tail(input logic [5:0] v, input logic [23:0] d);
    return {v, 2'b01, d};
  endfunction

  function automatic vec_t mk(input logic rb, input logic fv, input logic [31:0] f,
                              input logic tv, input logic [23:0] td, input logic tl,
                              input logic [3:0] tu, input logic cv, input logic [5:0] cvid);
    vec_t r;
    r.rst_b = rb; r.fv = fv; r.flit = f; r.rdy = 1'b1;
    r.tv = tv; r.td = td; r.tl = tl; r.tu = tu; r.cv = cv; r.cvid = cvid;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] f, input logic rdy);
    bus.flit_valid = fv;
    bus.flit_in    = f;
    bus.out_tready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  // Accept the next beat within a bounded window and check its fields
  task automatic wait_beat(input string nm, input logic [23:0] d, input logic l,
                           input logic [3:0] u);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      if (bus.out_tvalid === 1'b1) begin
        got = 1'b1;
        chk({nm, " tdata"}, 32'(bus.out_tdata), 32'(d));
        chk({nm, " tlast"}, 32'(bus.out_tlast), 32'(l));
        chk({nm, " tuser"}, 32'(bus.out_tuser), 32'(u));
      end
      tick();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no beat expected one", nm);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int act_cnt;
    drive(1'b0, 32'h0, 1'b0);

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst tvalid", 32'(bus.out_tvalid), 32'd0);
    chk("rst tlast", 32'(bus.out_tlast), 32'd0);
    chk("rst tdata", 32'(bus.out_tdata), 32'd0);
    chk("rst tuser", 32'(bus.out_tuser), 32'd0);
    chk("rst credit_valid", 32'(bus.credit_valid), 32'd0);
    chk("rst credit_vid", 32'(bus.credit_vid), 32'd0);
    chk("rst errors", 32'({err_overflow, err_proto}), 32'd0);
    chk("rst pkt_count", 32'(pkt_count), 32'd0);
    tick();

    // VID1 tag 5 packet, then interleaved VC0/VC2 packets
    vecs[0]  = mk(1'b1, 1'b1, hdr(6'd1, 4'h5),           1'b0, 24'h0,      1'b0, 4'h0, 1'b0, 6'd0);
    vecs[1]  = mk(1'b0, 1'b1, body(6'd1, 24'h000111),    1'b0, 24'h0,      1'b0, 4'h0, 1'b0, 6'd0);
    vecs[2]  = mk(1'b0, 1'b1, tail(6'd1, 24'h000222),    1'b1, 24'h000111, 1'b0, 4'h5, 1'b1, 6'd1);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,                     1'b1, 24'h000222, 1'b1, 4'h5, 1'b1, 6'd1);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,                     1'b0, 24'h0,      1'b0, 4'h0, 1'b1, 6'd1);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,                     1'b0, 24'h0,      1'b0, 4'h0, 1'b0, 6'd0);
    vecs[6]  = mk(1'b1, 1'b1, hdr(6'd0, 4'h3),           1'b0, 24'h0,      1'b0, 4'h0, 1'b0, 6'd0);
    vecs[7]  = mk(1'b0, 1'b1, hdr(6'd2, 4'h7),           1'b0, 24'h0,      1'b0, 4'h0, 1'b0, 6'd0);
    vecs[8]  = mk(1'b0, 1'b1, body(6'd0, 24'h0A0A00),    1'b0, 24'h0,      1'b0, 4'h0, 1'b1, 6'd0);
    vecs[9]  = mk(1'b0, 1'b1, body(6'd2, 24'h0B0B00),    1'b1, 24'h0A0A00, 1'b0, 4'h3, 1'b0, 6'd0);
    vecs[10] = mk(1'b0, 1'b1, tail(6'd0, 24'h0A0A01),    1'b0, 24'h0,      1'b0, 4'h0, 1'b1, 6'd0);
    vecs[11] = mk(1'b0, 1'b1, tail(6'd2, 24'h0B0B01),    1'b1, 24'h0A0A01, 1'b1, 4'h3, 1'b0, 6'd0);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,                     1'b0, 24'h0,      1'b0, 4'h0, 1'b1, 6'd0);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,                     1'b1, 24'h0B0B00, 1'b0, 4'h7, 1'b1, 6'd2);
    vecs[14] = mk(1'b0, 1'b0, 32'h0,                     1'b1, 24'h0B0B01, 1'b1, 4'h7, 1'b1, 6'd2);
    vecs[15] = mk(1'b0, 1'b0, 32'h0,                     1'b0, 24'h0,      1'b0, 4'h0, 1'b1, 6'd2);
    vecs[16] = mk(1'b0, 1'b0, 32'h0,                     1'b0, 24'h0,      1'b0, 4'h0, 1'b0, 6'd0);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].rst_b) do_reset();
      drive(vecs[i].fv, vecs[i].flit, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d tvalid", i), 32'(bus.out_tvalid), 32'(vecs[i].tv));
      if (vecs[i].tv) begin
        chk($sformatf("vec%0d tdata", i), 32'(bus.out_tdata), 32'(vecs[i].td));
        chk($sformatf("vec%0d tlast", i), 32'(bus.out_tlast), 32'(vecs[i].tl));
        chk($sformatf("vec%0d tuser", i), 32'(bus.out_tuser), 32'(vecs[i].tu));
      end
      chk($sformatf("vec%0d credit_valid", i), 32'(bus.credit_valid), 32'(vecs[i].cv));
      if (vecs[i].cv) begin
        chk($sformatf("vec%0d credit_vid", i), 32'(bus.credit_vid), 32'(vecs[i].cvid));
      end
      tick();
    end

    // tready held low for 5 cycles mid-packet
    do_reset();
    drive(1'b1, hdr(6'd1, 4'hA), 1'b1);        tick();
    drive(1'b1, body(6'd1, 24'h0000AB), 1'b1); tick();
    drive(1'b1, body(6'd1, 24'h0000CD), 1'b1);
    @(negedge clk);
    chk("stall first beat", 32'(bus.out_tdata), 32'h0000AB);
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(1'b1, tail(6'd1, 24'h0000EF), 1'b0);
      else        drive(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk($sformatf("stall%0d tvalid", c), 32'(bus.out_tvalid), 32'd1);
      chk($sformatf("stall%0d tdata", c), 32'(bus.out_tdata), 32'h0000CD);
      chk($sformatf("stall%0d tlast", c), 32'(bus.out_tlast), 32'd0);
      chk($sformatf("stall%0d tuser", c), 32'(bus.out_tuser), 32'hA);
      if (c > 0) chk($sformatf("stall%0d no credit", c), 32'(bus.credit_valid), 32'd0);
      tick();
    end
    wait_beat("stall resume", 24'h0000CD, 1'b0, 4'hA);
    wait_beat("stall tail", 24'h0000EF, 1'b1, 4'hA);

    // Overflow on VC3 while VC0 stream is stalled
    do_reset();
    drive(1'b1, hdr(6'd0, 4'h1), 1'b0);        tick();
    drive(1'b1, body(6'd0, 24'h00000F), 1'b0); tick();
    drive(1'b1, hdr(6'd3, 4'hC), 1'b0);        tick();
    drive(1'b1, body(6'd3, 24'h000301), 1'b0); tick();
    drive(1'b1, body(6'd3, 24'h000302), 1'b0); tick();
    drive(1'b1, tail(6'd3, 24'h000303), 1'b0); tick();
    drive(1'b1, body(6'd3, 24'h000304), 1'b0);
    @(negedge clk);
    chk("ovf before 5th", 32'(err_overflow), 32'd0);
    tick();
    drive(1'b1, tail(6'd0, 24'h000010), 1'b0);
    @(negedge clk);
    chk("ovf after 5th", 32'(err_overflow), 32'd1);
    tick();
    wait_beat("ovf vc0 body", 24'h00000F, 1'b0, 4'h1);
    wait_beat("ovf vc0 tail", 24'h000010, 1'b1, 4'h1);
    wait_beat("ovf vc3 b1", 24'h000301, 1'b0, 4'hC);
    wait_beat("ovf vc3 b2", 24'h000302, 1'b0, 4'hC);
    wait_beat("ovf vc3 tail", 24'h000303, 1'b1, 4'hC);
    act_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      if (bus.out_tvalid) act_cnt++;
      tick();
    end
    chk("ovf dropped flit absent", 32'(act_cnt), 32'd0);
    chk("ovf sticky", 32'(err_overflow), 32'd1);

    // Illegal VID 9: dropped, err_proto, no credit
    do_reset();
    drive(1'b1, {6'd9, 2'b11, 24'h500000}, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("vid9 err_proto", 32'(err_proto), 32'd1);
    chk("vid9 no credit a", 32'(bus.credit_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("vid9 no credit b", 32'(bus.credit_valid), 32'd0);
    chk("vid9 no beat", 32'(bus.out_tvalid), 32'd0);
    tick();

    // Body as first VC0 flit: discarded with credit
    do_reset();
    @(negedge clk);
    chk("rst clears err_proto", 32'(err_proto), 32'd0);
    tick();
    drive(1'b1, body(6'd0, 24'h000AAA), 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("orphan body err before pop", 32'(err_proto), 32'd0);
    tick();
    @(negedge clk);
    chk("orphan body err_proto", 32'(err_proto), 32'd1);
    chk("orphan body credit", 32'(bus.credit_valid), 32'd1);
    chk("orphan body credit vid", 32'(bus.credit_vid), 32'd0);
    chk("orphan body no beat", 32'(bus.out_tvalid), 32'd0);
    tick();
    @(negedge clk);
    chk("orphan body single credit", 32'(bus.credit_valid), 32'd0);
    tick();

    // Reset in mid-packet flushes buffers and returns no credits
    do_reset();
    drive(1'b1, hdr(6'd1, 4'h9), 1'b0);        tick();
    drive(1'b1, body(6'd1, 24'h000123), 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("midrst active before", 32'(bus.out_tvalid), 32'd1);
    do_reset();
    act_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      if (bus.out_tvalid || bus.credit_valid) act_cnt++;
      tick();
    end
    chk("midrst flushed", 32'(act_cnt), 32'd0);

    // Three packets, including a header+tail one-beat packet
    do_reset();
    drive(1'b1, hdr(6'd0, 4'h2), 1'b0);        tick();
    drive(1'b1, tail(6'd0, 24'h0000A1), 1'b0); tick();
    drive(1'b1, hdr(6'd1, 4'h4), 1'b0);        tick();
    drive(1'b1, body(6'd1, 24'h0000B1), 1'b0); tick();
    drive(1'b1, tail(6'd1, 24'h0000B2), 1'b0); tick();
    drive(1'b1, hdr(6'd2, 4'h6), 1'b0);        tick();
    drive(1'b1, tail(6'd2, 24'h0000C1), 1'b0); tick();
    wait_beat("p3 vc0 tail", 24'h0000A1, 1'b1, 4'h2);
    wait_beat("p3 vc1 body", 24'h0000B1, 1'b0, 4'h4);
    wait_beat("p3 vc1 tail", 24'h0000B2, 1'b1, 4'h4);
    wait_beat("p3 vc2 tail", 24'h0000C1, 1'b1, 4'h6);
    @(negedge clk);
`ifdef TL_EGRESS_STATS_EN
    chk("pkt_count", 32'(pkt_count), 32'd3);
`else
    chk("pkt_count", 32'(pkt_count), 32'd0);
`endif
    chk("p3 no errors", 32'({err_overflow, err_proto}), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
